// File: rtl/async_fifo_core_if.sv
// -----------------------------------------------------------------------------
// async_fifo_core_if
//
// Purpose: bundles the handshake and status signals of async_fifo_core so the
// FIFO and whoever drives it share a single connection point. The clock and
// reset are not part of the bundle; they stay as plain module ports.
//
// Signals (direction as seen from the FIFO, i.e. the slave modport):
//   wr_en      in   write request
//   wdata      in   write data, data_width bits
//   rd_en      in   read request
//   rdata      out  registered read data, data_width bits
//   full       out  FIFO holds fifo_depth words
//   empty      out  FIFO holds no words
//   valid      out  rdata was updated by a read at the last edge
//   overflow   out  a write was rejected at the last edge
//   underflow  out  a read was rejected at the last edge
//
// Handshake: a request is taken at a rising edge when its enable is high and
// the relevant flag (full for writes, empty for reads) was low before that
// edge. There is no backpressure beyond the flags; a request made against a
// set flag is dropped and reported by the matching one-cycle error strobe.
// -----------------------------------------------------------------------------
interface async_fifo_core_if #(
    parameter int data_width = 8
) ();

    logic                  wr_en;
    logic [data_width-1:0] wdata;
    logic                  rd_en;
    logic [data_width-1:0] rdata;
    logic                  full;
    logic                  empty;
    logic                  valid;
    logic                  overflow;
    logic                  underflow;

    // Producer/consumer side: drives requests, observes data and status.
    modport master (
        output wr_en,
        output wdata,
        output rd_en,
        input  rdata,
        input  full,
        input  empty,
        input  valid,
        input  overflow,
        input  underflow
    );

    // FIFO side: receives requests, drives data and status.
    modport slave (
        input  wr_en,
        input  wdata,
        input  rd_en,
        output rdata,
        output full,
        output empty,
        output valid,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/async_fifo_core.sv
// -----------------------------------------------------------------------------
// async_fifo_core
//
// Purpose: single-clock FIFO buffer between an upstream writer and a
// downstream reader. Read data is registered; rejected requests raise a
// one-cycle error strobe.
//
// Parameters:
//   data_width    width of each stored word
//   fifo_depth    number of storage entries, power of two
//   address_size  pointer width = log2(fifo_depth) + 1; the MSB is a wrap bit
//
// Ports:
//   wr_clk  in   the only clock, rising-edge triggered
//   rst     in   synchronous, active-low reset
//   bus     slave modport of async_fifo_core_if (requests, data, status)
//
// Behaviour summary:
//   - empty/full are decoded combinationally from the registered pointers
//     only, so no request input has a combinational path to any output.
//   - A write on full and a read on empty are dropped and flagged on
//     overflow/underflow for the following cycle.
//   - With both requests on an empty FIFO the write is taken but the read is
//     not: the new word is not forwarded to rdata in the same cycle.
//   - Reset clears pointers and the registered outputs but leaves the RAM
//     untouched; old words become unreachable because the pointers meet.
// -----------------------------------------------------------------------------
module async_fifo_core #(
    parameter int data_width   = 8,
    parameter int fifo_depth   = 16,
    parameter int address_size = 5
) (
    input  logic               wr_clk,
    input  logic               rst,
    async_fifo_core_if.slave   bus
);

    // Number of pointer bits that index the RAM (the MSB is the wrap bit).
    localparam int index_size = address_size - 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [data_width-1:0]   mem_q [fifo_depth];

    logic [address_size-1:0] wptr_q,      wptr_d;
    logic [address_size-1:0] rptr_q,      rptr_d;
    logic [data_width-1:0]   rdata_q,     rdata_d;
    logic                    valid_q,     valid_d;
    logic                    overflow_q,  overflow_d;
    logic                    underflow_q, underflow_d;

    // -------------------------------------------------------------------------
    // Flag decode and request acceptance
    // -------------------------------------------------------------------------
    logic                  full;
    logic                  empty;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [index_size-1:0] widx;
    logic [index_size-1:0] ridx;

    assign widx = wptr_q[index_size-1:0];
    assign ridx = rptr_q[index_size-1:0];

    // Pointers equal: nothing outstanding. Same slot but opposite wrap bit:
    // the writer is exactly one lap ahead of the reader.
    assign empty = (wptr_q == rptr_q);
    assign full  = (widx == ridx) && (wptr_q[address_size-1] != rptr_q[address_size-1]);

    // Acceptance uses the flags as they stood before the edge, so a full FIFO
    // with both requests takes the read only, and an empty FIFO takes the
    // write only.
    assign wr_accept = bus.wr_en && !full;
    assign rd_accept = bus.rd_en && !empty;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rdata_d     = rdata_q;
        valid_d     = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        // Pointers wrap naturally modulo 2**address_size.
        if (wr_accept) begin
            wptr_d = wptr_q + address_size'(1);
        end

        if (rd_accept) begin
            rptr_d  = rptr_q + address_size'(1);
            rdata_d = mem_q[ridx];
            valid_d = 1'b1;
        end

        // Strobes are recomputed each cycle, so they last exactly one cycle
        // per rejected request.
        overflow_d  = bus.wr_en && full;
        underflow_d = bus.rd_en && empty;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wr_clk) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rdata_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset. Writes are suppressed while reset is asserted so
    // that a request coinciding with reset has no side effect at all.
    always_ff @(posedge wr_clk) begin
        if (rst && wr_accept) begin
            mem_q[widx] <= bus.wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.rdata     = rdata_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.valid     = valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_async_fifo_core.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_core
//
// Directed bench for async_fifo_core (data_width 8, fifo_depth 16). Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_async_fifo_core;

    logic wr_clk;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    async_fifo_core_if #(.data_width(8)) bus ();

    async_fifo_core #(
        .data_width   (8),
        .fifo_depth   (16),
        .address_size (5)
    ) dut (
        .wr_clk (wr_clk),
        .rst    (rst),
        .bus    (bus)
    );

    // ------------------------------------------------------------------ clock
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // ---------------------------------------------------------------- drivers
    // Apply one set of requests, let one rising edge take them, then settle.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        bus.wr_en = w;
        bus.wdata = d;
        bus.rd_en = r;
        @(posedge wr_clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    // ------------------------------------------------------------- checking
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the expected set.
    task automatic expect_out(input string tag, input logic [7:0] e_rdata,
                              input logic e_valid, input logic e_full,
                              input logic e_empty, input logic e_ovf,
                              input logic e_unf);
        chk({tag, ".rdata"},     bus.rdata,           e_rdata);
        chk({tag, ".valid"},     {7'd0, bus.valid},     {7'd0, e_valid});
        chk({tag, ".full"},      {7'd0, bus.full},      {7'd0, e_full});
        chk({tag, ".empty"},     {7'd0, bus.empty},     {7'd0, e_empty});
        chk({tag, ".overflow"},  {7'd0, bus.overflow},  {7'd0, e_ovf});
        chk({tag, ".underflow"}, {7'd0, bus.underflow}, {7'd0, e_unf});
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        logic [7:0] d;
        logic [7:0] last;

        rst       = 1'b0;
        bus.wr_en = 1'b0;
        bus.wdata = 8'h00;
        bus.rd_en = 1'b0;

        // Reset held for two edges.
        @(posedge wr_clk);
        @(posedge wr_clk);
        #1;
        expect_out("reset", 8'h00, 0, 0, 1, 0, 0);
        rst = 1'b1;

        // Basic transfer.
        step(1, 8'hA5, 0);
        expect_out("basic.wr0", 8'h00, 0, 0, 0, 0, 0);
        step(1, 8'h3C, 0);
        expect_out("basic.wr1", 8'h00, 0, 0, 0, 0, 0);
        step(0, 8'h00, 1);
        expect_out("basic.rd0", 8'hA5, 1, 0, 0, 0, 0);
        step(0, 8'h00, 1);
        expect_out("basic.rd1", 8'h3C, 1, 0, 1, 0, 0);
        step(0, 8'h00, 0);
        expect_out("basic.idle", 8'h3C, 0, 0, 1, 0, 0);

        // Fill with 0xFF, 0x00 .. 0x0F; the 17th write is rejected.
        for (int n = 1; n <= 17; n++) begin
            d = (n == 1) ? 8'hFF : 8'(n - 2);
            step(1, d, 0);
            expect_out($sformatf("fill.%0d", n), 8'h3C, 0, n >= 16, 0, n == 17, 0);
        end
        step(0, 8'h00, 0);
        expect_out("fill.idle", 8'h3C, 0, 1, 0, 0, 0);

        // Drain 18 times: 16 words come out, the last two reads underflow.
        for (int n = 1; n <= 18; n++) begin
            step(0, 8'h00, 1);
            if (n <= 16) begin
                d = (n == 1) ? 8'hFF : 8'(n - 2);
                expect_out($sformatf("drain.%0d", n), d, 1, 0, n == 16, 0, 0);
            end else begin
                expect_out($sformatf("drain.%0d", n), 8'h0E, 0, 0, 1, 0, 1);
            end
        end
        step(0, 8'h00, 0);
        expect_out("drain.idle", 8'h0E, 0, 0, 1, 0, 0);

        // Simultaneous traffic at occupancy 8; both pointers wrap.
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(8'h40 + i), 0);
        end
        expect_out("sim.pre", 8'h0E, 0, 0, 0, 0, 0);
        for (int j = 0; j < 20; j++) begin
            step(1, 8'(8'h50 + j), 1);
            d = (j < 8) ? 8'(8'h40 + j) : 8'(8'h50 + j - 8);
            expect_out($sformatf("sim.%0d", j), d, 1, 0, 0, 0, 0);
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 8'h00, 1);
            expect_out($sformatf("sim.tail%0d", k), 8'(8'h5C + k), 1, 0, k == 7, 0, 0);
        end
        last = 8'h63;

        // Both requests on empty: write taken, read rejected, no pass-through.
        step(1, 8'h77, 1);
        expect_out("empty.both", last, 0, 0, 0, 0, 1);
        step(0, 8'h00, 1);
        expect_out("empty.rd", 8'h77, 1, 0, 1, 0, 0);

        // Both requests on full: read taken, write rejected.
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(8'h80 + i), 0);
        end
        expect_out("full.pre", 8'h77, 0, 1, 0, 0, 0);
        step(1, 8'h99, 1);
        expect_out("full.both", 8'h80, 1, 0, 0, 1, 0);
        for (int i = 1; i < 16; i++) begin
            step(0, 8'h00, 1);
            expect_out($sformatf("full.drain%0d", i), 8'(8'h80 + i), 1, 0, i == 15, 0, 0);
        end

        // Reset mid-operation with both requests active during the reset edge.
        for (int i = 0; i < 5; i++) begin
            step(1, 8'(8'hC0 + i), 0);
        end
        expect_out("mid.pre", 8'h8F, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1, 8'hEE, 1);
        rst = 1'b1;
        expect_out("mid.reset", 8'h00, 0, 0, 1, 0, 0);
        step(1, 8'h11, 0);
        expect_out("mid.wr", 8'h00, 0, 0, 0, 0, 0);
        step(0, 8'h00, 1);
        expect_out("mid.rd", 8'h11, 1, 0, 1, 0, 0);
        step(0, 8'h00, 1);
        expect_out("mid.unf", 8'h11, 0, 0, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
